// File: rtl/fx2_stream_writer.sv
// Buffers a 16-bit sample stream and writes it to the FX2 slave-FIFO port.
// Build with FX2_WR_PKTEND_EN defined to commit partial packets with a PKTEND pulse.
module fx2_stream_writer #(
  parameter int         DEPTH_LOG2 = 4,
  parameter int         PKT_WORDS  = 256,
  parameter logic [1:0] EP_ADDR    = 2'b10
) (
  input  logic        ADC_CLK,
  input  logic        RST_N,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        enable,
  input  logic        FX2_FLAGB,
  output logic [15:0] FD_OUT,
  output logic        FD_OE,
  output logic [1:0]  FIFOADR,
  output logic        FX2_SLWR,
  output logic        FX2_SLRD,
  output logic        FX2_SLOE,
  output logic        FX2_SLCS,
  output logic        FX2_PKTEND,
  output logic [15:0] drop_cnt
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

`ifdef FX2_WR_PKTEND_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_flag_q;
  logic [15:0]         r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_wr;
  logic [15:0]         w_head;
  logic                r_slwr;
  logic [15:0]         r_fd_out;
  logic                r_fd_oe;
  logic [15:0]         r_drop_cnt;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign w_push  = s_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  // Sample buffer storage carries data only, so it is not reset.
  always_ff @(posedge ADC_CLK) begin
    if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= s_data;
  end

  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_flag_q <= 1'b0;
    end else begin
      r_flag_q <= FX2_FLAGB;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_wr)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

`ifdef FX2_WR_PKTEND_EN
  localparam int             PKT_W    = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PKT_WORDS - 1);
  localparam logic [PKT_W-1:0] PKT_ONE  = 1;

  logic             r_pktend;
  logic [PKT_W-1:0] r_pkt_cnt;
  logic             w_flush_fire;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
`ifdef FX2_WR_PKTEND_EN
    w_flush_fire = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_wr = r_flag_q && !w_empty;
        if (!enable) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_wr = r_flag_q && !w_empty;
        if (w_empty) begin
`ifdef FX2_WR_PKTEND_EN
          w_state_nxt = (r_pkt_cnt != '0) ? ST_FLUSH : ST_IDLE;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef FX2_WR_PKTEND_EN
      // PKTEND waits for endpoint space so the short packet is not refused.
      ST_FLUSH: begin
        if (r_flag_q) begin
          w_flush_fire = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_slwr     <= 1'b1;
      r_fd_out   <= 16'h0000;
      r_fd_oe    <= 1'b0;
      r_drop_cnt <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_slwr  <= !w_wr;
      r_fd_oe <= (w_state_nxt != ST_IDLE);
      if (w_wr) r_fd_out <= w_head;
      if (s_valid && w_full) r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

`ifdef FX2_WR_PKTEND_EN
  // The FX2 commits full packets itself; the counter only tracks the remainder.
  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pkt_cnt <= '0;
      r_pktend  <= 1'b1;
    end else begin
      r_pktend <= !w_flush_fire;
      if (w_flush_fire)
        r_pkt_cnt <= '0;
      else if (w_wr)
        r_pkt_cnt <= (r_pkt_cnt == PKT_LAST) ? '0 : r_pkt_cnt + PKT_ONE;
    end
  end

  assign FX2_PKTEND = r_pktend;
`else
  assign FX2_PKTEND = 1'b1;
`endif

  assign s_ready  = !w_full;
  assign FD_OUT   = r_fd_out;
  assign FD_OE    = r_fd_oe;
  assign FIFOADR  = EP_ADDR;
  assign FX2_SLWR = r_slwr;
  assign FX2_SLRD = 1'b1;
  assign FX2_SLOE = 1'b1;
  assign FX2_SLCS = 1'b0;
  assign drop_cnt = r_drop_cnt;

endmodule
